// File: rtl/ysyx_23060278_pkg.sv
// rtl/ysyx_23060278_pkg.sv - shared widths, source ids and writeback request type
package ysyx_23060278_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    localparam logic SRC_LSU = 1'b0;
    localparam logic SRC_EXU = 1'b1;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/ysyx_23060278_scoreboard.sv
// rtl/ysyx_23060278_scoreboard.sv - pending-write busy bits, hazard queries and sticky error
module ysyx_23060278_scoreboard
    import ysyx_23060278_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_en,
    input  logic [AW-1:0] iss_rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_rd,
    input  logic          xfer_en,
    input  logic [AW-1:0] xfer_rd,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rd_busy,
    output logic          sb_err
);
    // x0 is never tracked, so its bit is held at zero and every query of it reads 0
    localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};

    logic [NREG-1:0] r_busy;
    logic            r_err;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic            w_iss_err;
    logic            w_xfer_err;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (iss_en) w_set[iss_rd] = 1'b1;
        if (clr_en) w_clr[clr_rd] = 1'b1;
    end

    assign w_iss_err  = iss_en && (iss_rd != '0) && r_busy[iss_rd] && !w_clr[iss_rd];
    assign w_xfer_err = xfer_en && (xfer_rd != '0) && !r_busy[xfer_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_err  <= 1'b0;
        end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & X0_MASK;
            if (w_iss_err || w_xfer_err) r_err <= 1'b1;
        end
    end

    assign rs1_busy = r_busy[rs1];
    assign rs2_busy = r_busy[rs2];
    assign rd_busy  = r_busy[iss_rd];
    assign sb_err   = r_err;
endmodule

// File: rtl/ysyx_23060278_wbu.sv
// rtl/ysyx_23060278_wbu.sv - round-robin EXU/LSU writeback arbiter and registered GPR write port
module ysyx_23060278_wbu
    import ysyx_23060278_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            rd_busy,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [AW-1:0]   exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            gpr_w_en,
    output logic [AW-1:0]   gpr_rd,
    output logic [XLEN-1:0] gpr_w_data,
    output logic            sb_err
);
    logic            r_ptr;
    logic            r_w_en;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_data;
    logic            w_gnt_lsu;
    logic            w_gnt_exu;
    logic            w_xfer;
    wb_req_t         w_win;

    // r_ptr names the source that wins when both are valid
    assign w_gnt_lsu = lsu_valid && (!exu_valid || (r_ptr == SRC_LSU));
    assign w_gnt_exu = exu_valid && !w_gnt_lsu;
    assign w_xfer    = w_gnt_lsu || w_gnt_exu;
    assign w_win     = w_gnt_exu ? {exu_rd, exu_data} : {lsu_rd, lsu_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= SRC_LSU;
            r_w_en <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else begin
            r_w_en <= w_xfer && (w_win.rd != '0);
            if (w_xfer) begin
                r_rd   <= w_win.rd;
                r_data <= w_win.data;
                r_ptr  <= w_gnt_exu ? SRC_LSU : SRC_EXU;
            end
        end
    end

    ysyx_23060278_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .clr_en   (r_w_en),
        .clr_rd   (r_rd),
        .xfer_en  (w_xfer),
        .xfer_rd  (w_win.rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy),
        .sb_err   (sb_err)
    );

    assign exu_ready  = w_gnt_exu;
    assign lsu_ready  = w_gnt_lsu;
    assign gpr_w_en   = r_w_en;
    assign gpr_rd     = r_rd;
    assign gpr_w_data = r_data;
endmodule

// File: tb/tb_ysyx_23060278_wbu.sv
// tb/tb_ysyx_23060278_wbu.sv - scoreboard-checked bench for the writeback unit
module tb_ysyx_23060278_wbu;
    import ysyx_23060278_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            iss_en;
    logic [AW-1:0]   iss_rd, rs1, rs2;
    logic            rs1_busy, rs2_busy, rd_busy;
    logic            exu_valid, exu_ready, lsu_valid, lsu_ready;
    logic [AW-1:0]   exu_rd, lsu_rd;
    logic [XLEN-1:0] exu_data, lsu_data;
    logic            gpr_w_en;
    logic [AW-1:0]   gpr_rd;
    logic [XLEN-1:0] gpr_w_data;
    logic            sb_err;

    always #5 clk = ~clk;

    ysyx_23060278_wbu dut (
        .clk(clk), .rst(rst), .iss_en(iss_en), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .gpr_w_en(gpr_w_en), .gpr_rd(gpr_rd), .gpr_w_data(gpr_w_data), .sb_err(sb_err)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // reference arbiter and expected-write queue
    logic      m_ptr = 1'b0;
    logic      m_wen = 1'b0;
    logic [1:0] m_gnt = 2'b00;
    bit        mon_on = 1'b0;
    wb_req_t   q[$];
    wb_req_t   exp_w;
    int        d_lsu_g = 0;
    int        d_exu_g = 0;

    always @(negedge clk) begin
        m_gnt = 2'b00;
        if (lsu_valid && (!exu_valid || !m_ptr)) m_gnt = 2'b01;
        else if (exu_valid)                       m_gnt = 2'b10;
        if (mon_on) begin
            chk("lsu_ready", {31'b0, lsu_ready}, {31'b0, m_gnt[0]});
            chk("exu_ready", {31'b0, exu_ready}, {31'b0, m_gnt[1]});
            chk("gpr_w_en", {31'b0, gpr_w_en}, {31'b0, m_wen});
            if (m_wen) begin
                if (q.size() == 0) chk("queue_empty", 32'd0, 32'd1);
                else begin
                    exp_w = q.pop_front();
                    chk("gpr_rd", {27'b0, gpr_rd}, {27'b0, exp_w.rd});
                    chk("gpr_w_data", gpr_w_data, exp_w.data);
                end
            end
            if (lsu_valid && lsu_ready) d_lsu_g++;
            if (exu_valid && exu_ready) d_exu_g++;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ptr = 1'b0;
            m_wen = 1'b0;
            q.delete();
        end else begin
            m_wen = 1'b0;
            if (m_gnt[0]) begin
                m_ptr = 1'b1;
                if (lsu_rd != 0) begin q.push_back({lsu_rd, lsu_data}); m_wen = 1'b1; end
            end else if (m_gnt[1]) begin
                m_ptr = 1'b0;
                if (exu_rd != 0) begin q.push_back({exu_rd, exu_data}); m_wen = 1'b1; end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        iss_en = 1'b1; iss_rd = rd;
        cyc();
        iss_en = 1'b0;
    endtask

    task automatic all_idle(input string tag);
        for (int i = 0; i < NREG; i++) begin
            rs1 = AW'(i); rs2 = AW'(NREG - 1 - i);
            #1;
            chk({tag, "_rs1"}, {31'b0, rs1_busy}, 32'd0);
            chk({tag, "_rs2"}, {31'b0, rs2_busy}, 32'd0);
        end
    endtask

    task automatic contend(input logic [AW-1:0] lrd, input logic [31:0] ld,
                           input logic [AW-1:0] erd, input logic [31:0] ed);
        lsu_valid = 1'b1; lsu_rd = lrd; lsu_data = ld;
        exu_valid = 1'b1; exu_rd = erd; exu_data = ed;
        for (int c = 0; c < 6 && (lsu_valid || exu_valid); c++) begin
            cyc();
            if (m_gnt[0]) lsu_valid = 1'b0;
            if (m_gnt[1]) exu_valid = 1'b0;
        end
        chk("contend_done", {30'b0, lsu_valid, exu_valid}, 32'd0);
        lsu_valid = 1'b0; exu_valid = 1'b0;
    endtask

    int g_l0, g_e0;

    initial begin
        rst = 1'b1; iss_en = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
        exu_valid = 0; exu_rd = 0; exu_data = 0; lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        cyc(); cyc();
        mon_on = 1'b1;
        rst = 1'b0;
        cyc();

        chk("reset_w_en", {31'b0, gpr_w_en}, 32'd0);
        chk("reset_sb_err", {31'b0, sb_err}, 32'd0);
        all_idle("reset");

        issue(5);
        exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF;
        #1 chk("t2_exu_ready", {31'b0, exu_ready}, 32'd1);
        cyc();
        exu_valid = 0; rs1 = 5;
        #1;
        chk("t2_w_en", {31'b0, gpr_w_en}, 32'd1);
        chk("t2_rd", {27'b0, gpr_rd}, 32'd5);
        chk("t2_data", gpr_w_data, 32'hDEADBEEF);
        chk("t2_busy_on_port", {31'b0, rs1_busy}, 32'd1);
        cyc();
        chk("t2_busy_cleared", {31'b0, rs1_busy}, 32'd0);

        issue(3); issue(7);
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h11;
        exu_valid = 1; exu_rd = 7; exu_data = 32'h22;
        #1;
        chk("t3_lsu_first", {31'b0, lsu_ready}, 32'd1);
        chk("t3_exu_wait", {31'b0, exu_ready}, 32'd0);
        contend(3, 32'h11, 7, 32'h22);
        chk("t3_rd7", {27'b0, gpr_rd}, 32'd7);
        chk("t3_data22", gpr_w_data, 32'h22);

        g_l0 = d_lsu_g; g_e0 = d_exu_g;
        for (int k = 0; k < 10; k++) begin
            issue(AW'(16 + k)); issue(AW'(1 + k));
            contend(AW'(16 + k), 32'hA000 + k, AW'(1 + k), 32'hB000 + k);
        end
        chk("rr_lsu_grants", d_lsu_g - g_l0, 32'd10);
        chk("rr_exu_grants", d_exu_g - g_e0, 32'd10);
        cyc();
        chk("rr_sb_err", {31'b0, sb_err}, 32'd0);

        exu_valid = 1; exu_rd = 0; exu_data = 32'h1234;
        #1 chk("x0_ready", {31'b0, exu_ready}, 32'd1);
        cyc();
        exu_valid = 0;
        #1 chk("x0_no_write", {31'b0, gpr_w_en}, 32'd0);
        issue(0);
        rs1 = 0;
        #1;
        chk("x0_busy", {31'b0, rs1_busy}, 32'd0);
        chk("x0_sb_err", {31'b0, sb_err}, 32'd0);

        issue(9);
        exu_valid = 1; exu_rd = 9; exu_data = 32'h99;
        cyc();
        exu_valid = 0; iss_en = 1; iss_rd = 9;
        #1 chk("x9_rd_busy", {31'b0, rd_busy}, 32'd1);
        cyc();
        iss_en = 0; rs1 = 9;
        #1;
        chk("x9_set_wins", {31'b0, rs1_busy}, 32'd1);
        chk("x9_sb_err", {31'b0, sb_err}, 32'd0);
        exu_valid = 1; exu_rd = 9; exu_data = 32'h999;
        cyc();
        exu_valid = 0;
        cyc();
        chk("x9_drained", {31'b0, rs1_busy}, 32'd0);
        lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC;
        cyc();
        lsu_valid = 0;
        chk("x12_err", {31'b0, sb_err}, 32'd1);
        cyc(); cyc();
        chk("x12_err_held", {31'b0, sb_err}, 32'd1);

        issue(20); issue(21);
        exu_valid = 1; exu_rd = 20; exu_data = 32'hAA;
        cyc();
        exu_valid = 0;
        chk("rst_pre_w_en", {31'b0, gpr_w_en}, 32'd1);
        rst = 1;
        cyc();
        rst = 0;
        #1;
        chk("rst_w_en", {31'b0, gpr_w_en}, 32'd0);
        chk("rst_rd", {27'b0, gpr_rd}, 32'd0);
        chk("rst_data", gpr_w_data, 32'd0);
        chk("rst_sb_err", {31'b0, sb_err}, 32'd0);
        all_idle("rst");

        issue(4); issue(6);
        lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
        exu_valid = 1; exu_rd = 6; exu_data = 32'h66;
        #1 chk("rst_ptr_lsu", {31'b0, lsu_ready}, 32'd1);
        contend(4, 32'h44, 6, 32'h66);
        cyc(); cyc();
        chk("pre_waw_err", {31'b0, sb_err}, 32'd0);
        issue(8); issue(8);
        chk("waw_err", {31'b0, sb_err}, 32'd1);
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
